// File: rtl/line_buf_5row_pkg.sv
// ---------------------------------------------------------------------------
// line_buf_5row_pkg
// Shared constants for the vertical window path: the line buffer, the
// 5-input max stage and the 5x5 column window block all build on these.
//   LB_BW_DEFAULT     default pixel width
//   LB_IMG_W_DEFAULT  default active pixels per line
//   LB_TAPS           vertical taps presented per column (rows r-4 .. r)
//   LB_RAMS           line RAMs needed to hold the previous lines
//   ROW_FILL_FULL     row_fill saturation value; windows are valid only here
// ---------------------------------------------------------------------------
package line_buf_5row_pkg;

   localparam int LB_BW_DEFAULT    = 8;
   localparam int LB_IMG_W_DEFAULT = 640;
   localparam int LB_TAPS          = 5;
   localparam int LB_RAMS          = LB_TAPS - 1;

   localparam logic [2:0] ROW_FILL_FULL = 3'd4;

   // Advance the count of completed lines, saturating once the line RAMs
   // all hold lines of the current frame.
   function automatic logic [2:0] row_fill_step(input logic [2:0] rf);
      return (rf >= ROW_FILL_FULL) ? ROW_FILL_FULL : rf + 3'd1;
   endfunction

endpackage

// File: rtl/line_buf_5row_line_ram.sv
// ---------------------------------------------------------------------------
// line_ram
// Simple dual-port line RAM, one write port and one read port, with a
// registered read. No reset on storage or read register, so it maps onto
// block RAM. A read and write of the same address in one cycle returns the
// old contents.
//   clk    clock, rising edge
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable; rdata holds its value while re is low
//   raddr  read address
//   rdata  registered read data
// ---------------------------------------------------------------------------
module line_ram #(
   parameter int BW    = 8,
   parameter int IMG_W = 640,
   localparam int AW   = $clog2(IMG_W)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [BW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [BW-1:0] rdata
);

   logic [BW-1:0] mem [IMG_W];
   logic [BW-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_reg <= mem[raddr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/line_buf_5row.sv
// ---------------------------------------------------------------------------
// line_buf_5row
// Vertical window generator. Stores the four previous lines of a raster
// stream and, for every accepted pixel, presents the five vertically aligned
// pixels of that column one cycle later.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   vs_in      frame start pulse; clears column and row tracking
//   den_in     pixel valid
//   data_in    pixel in raster order
//   data_out0  row r-4 (oldest)
//   data_out1  row r-3
//   data_out2  row r-2
//   data_out3  row r-1
//   data_out4  row r (current pixel, registered)
//   den_out    window valid (four full lines already buffered)
//   vs_out     vs_in delayed one cycle
// ---------------------------------------------------------------------------
module line_buf_5row
   import line_buf_5row_pkg::*;
#(
   parameter int BW    = LB_BW_DEFAULT,
   parameter int IMG_W = LB_IMG_W_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vs_in,
   input  logic          den_in,
   input  logic [BW-1:0] data_in,
   output logic [BW-1:0] data_out0,
   output logic [BW-1:0] data_out1,
   output logic [BW-1:0] data_out2,
   output logic [BW-1:0] data_out3,
   output logic [BW-1:0] data_out4,
   output logic          den_out,
   output logic          vs_out
);

   localparam int AW = $clog2(IMG_W);
   localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);

   logic [AW-1:0] col_reg, col_next;
   logic [2:0]    row_fill_reg, row_fill_next;
   logic [AW-1:0] rd_addr;
   logic [2:0]    row_base;
   logic          window_ok;

   // Shift writes into RAM1..3 happen one cycle after acceptance, once the
   // upstream RAM's read data has landed in its output register.
   logic          shift_we_d_reg;
   logic [AW-1:0] shift_addr_d_reg;

   logic [BW-1:0] tap4_reg;
   logic          taps_live_reg;
   logic          den_out_reg;
   logic          vs_out_reg;

   logic [BW-1:0] ram_rdata [LB_RAMS];

   // A coincident vs_in makes this pixel column 0 of row 0 of a new frame.
   always_comb begin
      rd_addr       = vs_in ? '0 : col_reg;
      row_base      = vs_in ? 3'd0 : row_fill_reg;
      col_next      = rd_addr;
      row_fill_next = row_base;
      window_ok     = den_in && (row_base == ROW_FILL_FULL);
      if (den_in) begin
         if (rd_addr == COL_LAST) begin
            col_next      = '0;
            row_fill_next = row_fill_step(row_base);
         end else begin
            col_next = rd_addr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_reg          <= '0;
         row_fill_reg     <= '0;
         shift_we_d_reg   <= 1'b0;
         shift_addr_d_reg <= '0;
         tap4_reg         <= '0;
         taps_live_reg    <= 1'b0;
         den_out_reg      <= 1'b0;
         vs_out_reg       <= 1'b0;
      end else begin
         col_reg          <= col_next;
         row_fill_reg     <= row_fill_next;
         shift_we_d_reg   <= den_in;
         shift_addr_d_reg <= rd_addr;
         den_out_reg      <= window_ok;
         vs_out_reg       <= vs_in;
         if (den_in) begin
            tap4_reg      <= data_in;
            taps_live_reg <= 1'b1;
         end
      end
   end

   // RAM0 takes the new pixel directly; RAM k takes what RAM k-1 held for
   // this column, giving a four-deep vertical shift per column. Consecutive
   // accepted pixels never share a column except across a vs restart, where
   // only the abandoned frame's contents can be disturbed.
   generate
      for (genvar gi = 0; gi < LB_RAMS; gi++) begin : g_ram
         if (gi == 0) begin : g_head
            line_ram #(.BW(BW), .IMG_W(IMG_W)) u_ram (
               .clk   (clk),
               .we    (den_in),
               .waddr (rd_addr),
               .wdata (data_in),
               .re    (den_in),
               .raddr (rd_addr),
               .rdata (ram_rdata[gi])
            );
         end else begin : g_tail
            line_ram #(.BW(BW), .IMG_W(IMG_W)) u_ram (
               .clk   (clk),
               .we    (shift_we_d_reg),
               .waddr (shift_addr_d_reg),
               .wdata (ram_rdata[gi-1]),
               .re    (den_in),
               .raddr (rd_addr),
               .rdata (ram_rdata[gi])
            );
         end
      end
   endgenerate

   // The RAM read registers cannot be reset, so the RAM taps are forced to
   // zero until the first pixel after reset has been read out.
   assign data_out0 = taps_live_reg ? ram_rdata[3] : '0;
   assign data_out1 = taps_live_reg ? ram_rdata[2] : '0;
   assign data_out2 = taps_live_reg ? ram_rdata[1] : '0;
   assign data_out3 = taps_live_reg ? ram_rdata[0] : '0;
   assign data_out4 = tap4_reg;
   assign den_out   = den_out_reg;
   assign vs_out    = vs_out_reg;

endmodule

// File: tb/tb_line_buf_5row.sv
module tb_line_buf_5row;

   localparam int BW    = 8;
   localparam int IMG_W = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vs_in;
   logic          den_in;
   logic [BW-1:0] data_in;
   logic [BW-1:0] data_out0, data_out1, data_out2, data_out3, data_out4;
   logic          den_out;
   logic          vs_out;

   line_buf_5row #(.BW(BW), .IMG_W(IMG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vs_in     (vs_in),
      .den_in    (den_in),
      .data_in   (data_in),
      .data_out0 (data_out0),
      .data_out1 (data_out1),
      .data_out2 (data_out2),
      .data_out3 (data_out3),
      .data_out4 (data_out4),
      .den_out   (den_out),
      .vs_out    (vs_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         row;
      int         col;
      logic [7:0] e0, e1, e2, e3, e4;
      logic       den;
   } vec_t;

   vec_t       vtab [6];
   logic [7:0] last_exp [5];
   bit         last_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " out0"}, 32'(data_out0), 32'd0);
      chk({tag, " out1"}, 32'(data_out1), 32'd0);
      chk({tag, " out2"}, 32'(data_out2), 32'd0);
      chk({tag, " out3"}, 32'(data_out3), 32'd0);
      chk({tag, " out4"}, 32'(data_out4), 32'd0);
      chk({tag, " den"},  32'(den_out),   32'd0);
      chk({tag, " vs"},   32'(vs_out),    32'd0);
   endtask

   task automatic chk_taps(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
      chk({tag, " out0"}, 32'(data_out0), 32'(e0));
      chk({tag, " out1"}, 32'(data_out1), 32'(e1));
      chk({tag, " out2"}, 32'(data_out2), 32'(e2));
      chk({tag, " out3"}, 32'(data_out3), 32'(e3));
   endtask

   // One accepted pixel at (r,c) of a frame whose pixels are base + r*16 + c.
   // Entered and left on a falling edge.
   task automatic pix(input bit vs, input int r, input int c, input logic [7:0] base,
                      input string tag);
      logic [7:0] v;
      logic [7:0] e [4];
      v = base + 8'(r * 16 + c);
      for (int k = 0; k < 4; k++) e[k] = base + 8'((r - 4 + k) * 16 + c);
      vs_in = vs; den_in = 1'b1; data_in = v;
      @(negedge clk);
      vs_in = 1'b0; den_in = 1'b0; data_in = 8'($urandom);
      $display("%s r=%0d c=%0d vs=%0d in=%02h -> %02h %02h %02h %02h %02h den=%0d",
               tag, r, c, vs, v, data_out0, data_out1, data_out2, data_out3, data_out4, den_out);
      chk({tag, " den"}, 32'(den_out), (r >= 4) ? 32'd1 : 32'd0);
      chk({tag, " vs"},  32'(vs_out), 32'(vs));
      chk({tag, " out4"}, 32'(data_out4), 32'(v));
      last_exp[4] = v;
      last_valid  = (r >= 4);
      if (r >= 4) begin
         chk_taps(tag, e[0], e[1], e[2], e[3]);
         for (int k = 0; k < 4; k++) last_exp[k] = e[k];
      end
      if (base == 8'h00) begin
         for (int i = 0; i < 6; i++) begin
            if (vtab[i].row == r && vtab[i].col == c) begin
               chk({tag, " tab den"},  32'(den_out),   32'(vtab[i].den));
               chk({tag, " tab out4"}, 32'(data_out4), 32'(vtab[i].e4));
               if (vtab[i].den) chk_taps({tag, " tab"}, vtab[i].e0, vtab[i].e1, vtab[i].e2, vtab[i].e3);
            end
         end
      end
   endtask

   // Cycles with den_in low: window must drop and all taps must hold.
   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         vs_in = 1'b0; den_in = 1'b0; data_in = 8'($urandom);
         @(negedge clk);
         $display("%s idle -> out4=%02h den=%0d", tag, data_out4, den_out);
         chk({tag, " idle den"}, 32'(den_out), 32'd0);
         chk({tag, " idle out4"}, 32'(data_out4), 32'(last_exp[4]));
         if (last_valid) chk_taps({tag, " idle"}, last_exp[0], last_exp[1], last_exp[2], last_exp[3]);
      end
   endtask

   task automatic vs_only(input string tag);
      vs_in = 1'b1; den_in = 1'b0; data_in = 8'($urandom);
      @(negedge clk);
      vs_in = 1'b0;
      $display("%s vs pulse -> vs_out=%0d den=%0d", tag, vs_out, den_out);
      chk({tag, " vs_out"}, 32'(vs_out), 32'd1);
      chk({tag, " vs den"}, 32'(den_out), 32'd0);
      last_valid = 1'b0;
   endtask

   initial begin
      int k;
      vtab[0] = '{row: 4, col: 2, e0: 8'h02, e1: 8'h12, e2: 8'h22, e3: 8'h32, e4: 8'h42, den: 1'b1};
      vtab[1] = '{row: 5, col: 0, e0: 8'h10, e1: 8'h20, e2: 8'h30, e3: 8'h40, e4: 8'h50, den: 1'b1};
      vtab[2] = '{row: 5, col: 7, e0: 8'h17, e1: 8'h27, e2: 8'h37, e3: 8'h47, e4: 8'h57, den: 1'b1};
      vtab[3] = '{row: 4, col: 0, e0: 8'h00, e1: 8'h10, e2: 8'h20, e3: 8'h30, e4: 8'h40, den: 1'b1};
      vtab[4] = '{row: 3, col: 7, e0: 8'h00, e1: 8'h00, e2: 8'h00, e3: 8'h00, e4: 8'h37, den: 1'b0};
      vtab[5] = '{row: 4, col: 7, e0: 8'h07, e1: 8'h17, e2: 8'h27, e3: 8'h37, e4: 8'h47, den: 1'b1};
      last_valid = 1'b0;
      for (int i = 0; i < 5; i++) last_exp[i] = 8'h00;

      // Asynchronous reset: checked before any clock edge has occurred.
      rst_n = 1'b1; vs_in = 1'b0; den_in = 1'b0; data_in = 8'h00;
      #1 rst_n = 1'b0;
      #1;
      $display("reset async -> %02h %02h %02h %02h %02h den=%0d", data_out0, data_out1,
               data_out2, data_out3, data_out4, den_out);
      chk_zero("rst_async");
      for (int i = 0; i < 3; i++) begin
         vs_in = 1'($urandom); den_in = 1'($urandom); data_in = 8'($urandom);
         @(negedge clk);
         $display("reset held -> den=%0d out4=%02h", den_out, data_out4);
         chk_zero("rst_held");
      end
      vs_in = 1'b0; den_in = 1'b0; data_in = 8'h00;
      rst_n = 1'b1;

      // Continuous fill over six lines.
      vs_only("cont");
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < IMG_W; c++)
            pix(1'b0, r, c, 8'h00, "cont");

      // Gapped input: den pattern 1,0,0,1 repeated.
      vs_only("gap");
      k = 0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < IMG_W; c++) begin
            while (!((k % 4) == 0 || (k % 4) == 3)) begin
               idle(1, "gap");
               k++;
            end
            pix(1'b0, r, c, 8'h00, "gap");
            k++;
         end
      idle(2, "gap");

      // Frame restart with vs_in coincident with a pixel at row 5 col 3.
      vs_only("rstrt");
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < IMG_W; c++)
            pix(1'b0, r, c, 8'h00, "rstrt_old");
      for (int c = 0; c < 3; c++) pix(1'b0, 5, c, 8'h00, "rstrt_old");
      pix(1'b1, 0, 0, 8'h80, "rstrt_new");
      for (int r = 0; r < 6; r++)
         for (int c = (r == 0) ? 1 : 0; c < IMG_W; c++)
            pix(1'b0, r, c, 8'h80, "rstrt_new");

      // Asynchronous reset in the middle of row 4 (after col 4).
      vs_only("arst");
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < IMG_W; c++)
            pix(1'b0, r, c, 8'h20, "arst_pre");
      for (int c = 0; c < 5; c++) pix(1'b0, 4, c, 8'h20, "arst_pre");
      #2 rst_n = 1'b0;
      #1;
      $display("reset mid-line -> %02h %02h %02h %02h %02h den=%0d", data_out0, data_out1,
               data_out2, data_out3, data_out4, den_out);
      chk_zero("arst_now");
      @(negedge clk);
      chk_zero("arst_held");
      rst_n = 1'b1;
      last_valid = 1'b0;
      last_exp[4] = 8'h00;
      idle(1, "arst_post");
      chk("arst_post out0", 32'(data_out0), 32'd0);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < IMG_W; c++)
            pix(1'b0, r, c, 8'h30, "arst_post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
